regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port rs_addr  in  NREAD*ADDR_WIDTH  read indices; port k in slice k.
REQ-007 SHALL have port rs_data  out  NREAD*DATA_WIDTH  read data, combinational.
REQ-008 SHALL have port rs_busy  out  NREAD  1 = read register has an outstanding producer.
REQ-009 SHALL have port wb_valid  in  1  writeback strobe.
REQ-010 SHALL have ports wb_addr  in  ADDR_WIDTH and wb_data  in  DATA_WIDTH  writeback target and value.
REQ-011 SHALL have port iss_valid  in  1  issue request; marks iss_rd busy when accepted.
REQ-012 SHALL have port iss_rd  in  ADDR_WIDTH  destination of issuing instruction.
REQ-013 SHALL have port iss_ready  out  1  issue accepted this cycle if iss_valid.
REQ-014 SHALL have port flush  in  1  clears all busy bits.
REQ-015 SHALL have port err_spurious  out  1  sticky: writeback hit a non-busy register.

Function
REQ-016 SHALL hold 2**ADDR_WIDTH data registers plus one busy bit per register.
REQ-017 SHALL hardwire register 0: reads return 0, rs_busy 0, writes ignored, never marked busy, never raises err_spurious.
REQ-018 SHALL, on wb_valid with wb_addr!=0, write wb_data at the next edge; array latency 1 cycle.
REQ-019 SHALL bypass: rs_addr k == wb_addr != 0 with wb_valid returns wb_data and rs_busy k = 0 in the same cycle.
REQ-020 SHALL set iss_ready = (iss_rd==0) or !busy[iss_rd] or (wb_valid and wb_addr==iss_rd); flush does not affect iss_ready.
REQ-021 SHALL, on iss_valid and iss_ready and iss_rd!=0 and !flush, set busy[iss_rd] at the next edge.
REQ-022 SHALL clear busy[wb_addr] on wb_valid unless the same register is issued that cycle; issue wins (busy stays 1).
REQ-023 SHALL, on flush, clear all busy bits at the next edge; flush overrides a same-cycle issue; the same-cycle writeback still writes data.
REQ-024 SHALL set err_spurious at the next edge when wb_valid, wb_addr!=0 and busy[wb_addr]==0; data still written; cleared only by reset.
REQ-025 SHALL report rs_busy k = busy[rs_addr k] except under bypass (REQ-019).
REQ-026 SHALL treat all read ports independently; identical addresses on several ports return identical values.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all data registers, all busy bits and err_spurious.
REQ-028 SHALL, after reset, drive rs_data all 0, rs_busy all 0, iss_ready 1, err_spurious 0.
REQ-029 SHALL discard any writeback or issue coinciding with the edge on which rst_n is low; reset mid-operation leaves no partial state.

Structure
REQ-030 SHALL take default ADDR_WIDTH, DATA_WIDTH, NREAD values from shared package regfile_pkg.
REQ-031 SHALL implement each read port (array read, x0 zeroing, bypass, busy lookup) as sub-module regfile_read_port, instantiated NREAD times.
REQ-032 SHALL contain no simulation print statements in synthesizable code.

Verification
REQ-033 SHALL cover: reset, then read x5 on both ports -> rs_data 0, rs_busy 0, iss_ready 1.
REQ-034 SHALL cover: wb x3=0xDEADBEEF while port0 reads x3 -> same-cycle 0xDEADBEEF via bypass; next cycle 0xDEADBEEF from array.
REQ-035 SHALL cover: issue x7, next cycle issue x7 again -> iss_ready 0; wb x7 that cycle -> iss_ready 1, busy[x7] stays 1.
REQ-036 SHALL cover: wb x0=0x1234 and issue x0 -> x0 reads 0, rs_busy 0, err_spurious 0.
REQ-037 SHALL cover: issue x1,x2 then flush with issue x4 -> all busy 0 next cycle; later wb x4=0x55 -> err_spurious 1, x4 reads 0x55.
REQ-038 SHALL cover: rst_n low mid-stream with x9 busy and data written -> x9 reads 0, rs_busy 0, err_spurious 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared default geometry for the register file scoreboard.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int c_addr_width = 5;
    localparam int c_data_width = 32;
    localparam int c_nread      = 2;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Brief    : One combinational read port: array read, x0 zeroing,
//            writeback bypass and busy lookup.
// Revision : 1.0
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic [ADDR_WIDTH-1:0]                        rd_addr,
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   mem,
    input  logic [(2**ADDR_WIDTH)-1:0]                   busy,
    input  logic                                         wb_valid,
    input  logic [ADDR_WIDTH-1:0]                        wb_addr,
    input  logic [DATA_WIDTH-1:0]                        wb_data,
    output logic [DATA_WIDTH-1:0]                        rd_data,
    output logic                                         rd_busy
);

    logic w_is_x0;
    logic w_bypass;

    assign w_is_x0  = (rd_addr == '0);
    assign w_bypass = wb_valid && (wb_addr == rd_addr) && !w_is_x0;

    always_comb begin
        rd_data = mem[rd_addr];
        rd_busy = busy[rd_addr];
        // The in-flight writeback resolves the hazard this cycle.
        if (w_bypass) begin
            rd_data = wb_data;
            rd_busy = 1'b0;
        end
        if (w_is_x0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Register file with per-register busy scoreboard, writeback
//            bypass, issue gating, flush and sticky spurious-writeback flag.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width,
    parameter int NREAD      = c_nread
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD*ADDR_WIDTH-1:0]   rs_addr,
    output logic [NREAD*DATA_WIDTH-1:0]   rs_data,
    output logic [NREAD-1:0]              rs_busy,
    input  logic                          wb_valid,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_rd,
    output logic                          iss_ready,
    input  logic                          flush,
    output logic                          err_spurious
);

    localparam int c_depth = 2**ADDR_WIDTH;

    logic [c_depth-1:0][DATA_WIDTH-1:0] r_mem;
    logic [c_depth-1:0]                 r_busy;
    logic [c_depth-1:0]                 w_busy_nxt;
    logic                               r_err;
    logic                               w_wb_live;
    logic                               w_iss_fire;

    assign w_wb_live  = wb_valid && (wb_addr != '0);
    assign iss_ready  = (iss_rd == '0) || !r_busy[iss_rd] ||
                        (wb_valid && (wb_addr == iss_rd));
    assign w_iss_fire = iss_valid && iss_ready && (iss_rd != '0) && !flush;

    // Priority low to high: writeback clear, issue set, flush clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_live) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_iss_fire) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem  <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_wb_live) begin
                r_mem[wb_addr] <= wb_data;
                if (!r_busy[wb_addr]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign err_spurious = r_err;

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
            regfile_read_port #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_rd_port (
                .rd_addr  (rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
                .mem      (r_mem),
                .busy     (r_busy),
                .wb_valid (wb_valid),
                .wb_addr  (wb_addr),
                .wb_data  (wb_data),
                .rd_data  (rs_data[k*DATA_WIDTH +: DATA_WIDTH]),
                .rd_busy  (rs_busy[k])
            );
        end
    endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed scenarios plus randomized traffic against a
//            behavioural scoreboard model.
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rs_addr;
    logic [NR*DW-1:0]  rs_data;
    logic [NR-1:0]     rs_busy;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              iss_ready;
    logic              flush;
    logic              err_spurious;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_err;

    regfile_scoreboard #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NREAD      (NR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_addr      (rs_addr),
        .rs_data      (rs_data),
        .rs_busy      (rs_busy),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .flush        (flush),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_data(int a);
        if (a == 0) return '0;
        if (wb_valid && int'(wb_addr) == a) return wb_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int a);
        if (a == 0) return 1'b0;
        if (wb_valid && int'(wb_addr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_ready();
        if (iss_rd == '0) return 1'b1;
        if (wb_valid && wb_addr == iss_rd) return 1'b1;
        return !m_busy[iss_rd];
    endfunction

    function automatic logic [DW-1:0] port_data(int k);
        return rs_data[k*DW +: DW];
    endfunction

    task automatic set_rd(int k, int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
        rs_addr   = '0;
    endtask

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic tick();
        bit fire;
        fire = iss_valid && exp_ready() && (iss_rd != '0) && !flush;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (wb_valid && wb_addr != '0) begin
                if (!m_busy[wb_addr]) m_err = 1'b1;
                m_mem[wb_addr]  = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (fire) m_busy[iss_rd] = 1'b1;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_rd(0, 5);
        set_rd(1, 5);
        iss_rd = 5'd5;
        #2;
        for (int k = 0; k < NR; k++) begin
            n_checks++;
            if (port_data(k) !== 32'h0)
                $display("FAIL reset_rs_data%0d: got %h expected %h", k, port_data(k), 32'h0);
            else n_pass++;
            n_checks++;
            if (rs_busy[k] !== 1'b0)
                $display("FAIL reset_rs_busy%0d: got %b expected 0", k, rs_busy[k]);
            else n_pass++;
        end
        n_checks++;
        if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready: got %b expected 1", iss_ready);
        else n_pass++;
        n_checks++;
        if (err_spurious !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_spurious);
        else n_pass++;
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        wb_valid = 1'b1;
        wb_addr  = 5'd3;
        wb_data  = 32'hDEADBEEF;
        set_rd(0, 3);
        set_rd(1, 3);
        #2;
        for (int k = 0; k < NR; k++) begin
            n_checks++;
            if (port_data(k) !== 32'hDEADBEEF || rs_busy[k] !== 1'b0)
                $display("FAIL bypass_port%0d: got %h/%b expected deadbeef/0", k, port_data(k), rs_busy[k]);
            else n_pass++;
        end
        tick();
        idle();
        set_rd(0, 3);
        #2;
        n_checks++;
        if (port_data(0) !== 32'hDEADBEEF)
            $display("FAIL array_read_x3: got %h expected deadbeef", port_data(0));
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        #2;
        n_checks++;
        if (iss_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b expected 1", iss_ready);
        else n_pass++;
        tick();
        #2;
        n_checks++;
        if (iss_ready !== 1'b0) $display("FAIL b2b_second_ready: got %b expected 0", iss_ready);
        else n_pass++;
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 32'h000000A5;
        set_rd(0, 7);
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) $display("FAIL b2b_wb_ready: got %b expected 1", iss_ready);
        else n_pass++;
        tick();
        idle();
        set_rd(0, 7);
        #2;
        n_checks++;
        if (rs_busy[0] !== 1'b1 || port_data(0) !== 32'h000000A5)
            $display("FAIL b2b_x7_state: got %b/%h expected 1/000000a5", rs_busy[0], port_data(0));
        else n_pass++;
        n_checks++;
        if (err_spurious !== 1'b0) $display("FAIL b2b_err: got %b expected 0", err_spurious);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        wb_valid  = 1'b1;
        wb_addr   = '0;
        wb_data   = 32'h00001234;
        iss_valid = 1'b1;
        iss_rd    = '0;
        set_rd(0, 0);
        set_rd(1, 0);
        #2;
        n_checks++;
        if (port_data(0) !== 32'h0 || rs_busy[0] !== 1'b0 || iss_ready !== 1'b1)
            $display("FAIL x0_same_cycle: got %h/%b/%b expected 0/0/1", port_data(0), rs_busy[0], iss_ready);
        else n_pass++;
        tick();
        idle();
        #2;
        n_checks++;
        if (port_data(1) !== 32'h0 || rs_busy[1] !== 1'b0 || err_spurious !== 1'b0)
            $display("FAIL x0_after: got %h/%b/%b expected 0/0/0", port_data(1), rs_busy[1], err_spurious);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        iss_valid = 1'b1;
        iss_rd    = 5'd1;
        tick();
        iss_rd    = 5'd2;
        tick();
        iss_rd    = 5'd4;
        flush     = 1'b1;
        tick();
        idle();
        set_rd(0, 1);
        set_rd(1, 2);
        iss_rd = 5'd4;
        #2;
        n_checks++;
        if (rs_busy !== 2'b00) $display("FAIL flush_busy_x1x2: got %b expected 00", rs_busy);
        else n_pass++;
        n_checks++;
        if (iss_ready !== 1'b1) $display("FAIL flush_x4_ready: got %b expected 1", iss_ready);
        else n_pass++;
        wb_valid = 1'b1;
        wb_addr  = 5'd4;
        wb_data  = 32'h00000055;
        tick();
        idle();
        set_rd(0, 4);
        #2;
        n_checks++;
        if (err_spurious !== 1'b1) $display("FAIL flush_err: got %b expected 1", err_spurious);
        else n_pass++;
        n_checks++;
        if (port_data(0) !== 32'h00000055)
            $display("FAIL flush_x4_data: got %h expected 00000055", port_data(0));
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_valid  = 1'b1;
        wb_addr   = 5'd9;
        wb_data   = 32'hCAFEF00D;
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        idle();
        set_rd(0, 9);
        #2;
        n_checks++;
        if (rs_busy[0] !== 1'b1 || port_data(0) !== 32'hCAFEF00D || err_spurious !== 1'b1)
            $display("FAIL mid_pre_state: got %b/%h/%b expected 1/cafef00d/1", rs_busy[0], port_data(0), err_spurious);
        else n_pass++;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (port_data(0) !== 32'h0 || rs_busy[0] !== 1'b0 || err_spurious !== 1'b0)
            $display("FAIL mid_async_clear: got %h/%b/%b expected 0/0/0", port_data(0), rs_busy[0], err_spurious);
        else n_pass++;
        wb_valid  = 1'b1;
        wb_addr   = 5'd9;
        wb_data   = 32'h11111111;
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        idle();
        rst_n = 1'b1;
        set_rd(0, 9);
        iss_rd = 5'd9;
        #2;
        n_checks++;
        if (port_data(0) !== 32'h0 || rs_busy[0] !== 1'b0 || iss_ready !== 1'b1 || err_spurious !== 1'b0)
            $display("FAIL mid_discard: got %h/%b/%b/%b expected 0/0/1/0", port_data(0), rs_busy[0], iss_ready, err_spurious);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_addr   = AW'($urandom_range(0, 7));
            wb_data   = $urandom;
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, 7));
            #2;
            for (int k = 0; k < NR; k++) begin
                int a;
                a = int'(rs_addr[k*AW +: AW]);
                n_checks++;
                if (port_data(k) !== exp_data(a))
                    $display("FAIL rand_rs_data%0d x%0d cyc%0d: got %h expected %h", k, a, n, port_data(k), exp_data(a));
                else n_pass++;
                n_checks++;
                if (rs_busy[k] !== exp_busy(a))
                    $display("FAIL rand_rs_busy%0d x%0d cyc%0d: got %b expected %b", k, a, n, rs_busy[k], exp_busy(a));
                else n_pass++;
            end
            n_checks++;
            if (iss_ready !== exp_ready())
                $display("FAIL rand_iss_ready cyc%0d: got %b expected %b", n, iss_ready, exp_ready());
            else n_pass++;
            n_checks++;
            if (err_spurious !== m_err)
                $display("FAIL rand_err cyc%0d: got %b expected %b", n, err_spurious, m_err);
            else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_clear();
        test_reset();
        test_bypass();
        test_back_to_back();
        test_x0();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_scoreboard
`default_nettype wire
